// File: rtl/prog_timer_pkg.sv
// Shared definitions for the programmable timer: direction/mode encodings,
// run state, and the prescaler width helper.
package prog_timer_pkg;

  localparam logic DIR_UP        = 1'b0;
  localparam logic DIR_DOWN      = 1'b1;
  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } run_state_t;

  // A divide-by-1 still needs a 1-bit register to stay legal.
  function automatic int unsigned pre_width(input int unsigned prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/prog_timer_prescaler.sv
// Clock divider: raises tick_evt on every PRESCALE-th enabled cycle.
module prescaler
  import prog_timer_pkg::*;
#(
  parameter int unsigned PRESCALE = 100000000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic sync_clr,
  output logic tick_evt
);

  localparam int unsigned   PW   = pre_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_cnt;

  assign tick_evt = enable && (pre_cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt <= '0;
    end else if (sync_clr) begin
      pre_cnt <= '0;
    end else if (enable) begin
      pre_cnt <= tick_evt ? '0 : pre_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/prog_timer.sv
// Programmable up/down timer with modulus, load, clear and one-shot mode;
// tick/tc pulses allow cascading timers.
module prog_timer
  import prog_timer_pkg::*;
#(
  parameter int unsigned      WIDTH     = 16,
  parameter int unsigned      PRESCALE  = 100000000,
  parameter logic [WIDTH-1:0] MAX_COUNT = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             dir,
  input  logic             oneshot,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tc,
  output logic             done
);

  logic             tick_evt;
  run_state_t       state, state_nx;
  logic [WIDTH-1:0] count_nx;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] load_clamped;
  logic             tick_nx, tc_nx;

  prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .sync_clr (clear | load),
    .tick_evt (tick_evt)
  );

  always_comb begin
    count_nx     = count;
    state_nx     = state;
    tick_nx      = 1'b0;
    tc_nx        = 1'b0;
    term         = (dir == DIR_UP) ? MAX_COUNT : '0;
    load_clamped = (load_value > MAX_COUNT) ? MAX_COUNT : load_value;

    if (clear) begin
      count_nx = '0;
      state_nx = ST_RUN;
    end else if (load) begin
      count_nx = load_clamped;
      state_nx = ST_RUN;
    end else if (tick_evt) begin
      tick_nx = 1'b1;
      if (state == ST_RUN) begin
        if (count != term) begin
          count_nx = (dir == DIR_UP) ? count + 1'b1 : count - 1'b1;
        end else begin
          tc_nx = 1'b1;
          // Wrap to the modulus explicitly rather than relying on overflow.
          if (oneshot == MODE_ONESHOT) state_nx = ST_DONE;
          else count_nx = (dir == DIR_UP) ? '0 : MAX_COUNT;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      state <= ST_RUN;
      tick  <= 1'b0;
      tc    <= 1'b0;
    end else begin
      count <= count_nx;
      state <= state_nx;
      tick  <= tick_nx;
      tc    <= tc_nx;
    end
  end

  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_prog_timer.sv
// Scoreboard bench for prog_timer: one 4/4/9 instance and one 4/1/15 instance
// driven from shared stimulus and checked every cycle against a reference model.
module tb_prog_timer;

  typedef struct {
    int pre;
    int cnt;
    bit done;
    bit tick;
    bit tc;
  } mstate_t;

  typedef struct packed {
    logic [6:0] a;
    logic [6:0] b;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0, dir = 1'b0, oneshot = 1'b0, clear = 1'b0, load = 1'b0;
  logic [3:0] lv = 4'd0;

  logic [3:0] a_count, b_count;
  logic       a_tick, a_tc, a_done, b_tick, b_tc, b_done;

  int total = 0;
  int bad = 0;
  int ticks_a = 0, tcs_a = 0, tcs_b = 0;

  mstate_t ma, mb;
  exp_t    q[$];

  always #5 clk = ~clk;

  prog_timer #(.WIDTH(4), .PRESCALE(4), .MAX_COUNT(4'd9)) dut_a (
    .clk(clk), .reset(rst_n), .enable(enable), .dir(dir), .oneshot(oneshot),
    .clear(clear), .load(load), .load_value(lv),
    .count(a_count), .tick(a_tick), .tc(a_tc), .done(a_done)
  );

  prog_timer #(.WIDTH(4), .PRESCALE(1), .MAX_COUNT(4'd15)) dut_b (
    .clk(clk), .reset(rst_n), .enable(enable), .dir(dir), .oneshot(oneshot),
    .clear(clear), .load(load), .load_value(lv),
    .count(b_count), .tick(b_tick), .tc(b_tc), .done(b_done)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic mstate_t mzero();
    mstate_t z;
    z.pre = 0; z.cnt = 0; z.done = 0; z.tick = 0; z.tc = 0;
    return z;
  endfunction

  function automatic mstate_t mstep(input mstate_t s, input int p, input int m);
    mstate_t n = s;
    n.tick = 0;
    n.tc   = 0;
    if (clear) begin
      n.cnt = 0; n.pre = 0; n.done = 0;
    end else if (load) begin
      n.cnt = (int'(lv) > m) ? m : int'(lv);
      n.pre = 0; n.done = 0;
    end else if (enable) begin
      if (s.pre == p - 1) begin
        n.pre  = 0;
        n.tick = 1;
        if (!s.done) begin
          if (!dir && s.cnt < m)     n.cnt = s.cnt + 1;
          else if (dir && s.cnt > 0) n.cnt = s.cnt - 1;
          else begin
            n.tc = 1;
            if (oneshot) n.done = 1;
            else         n.cnt  = dir ? m : 0;
          end
        end
      end else begin
        n.pre = s.pre + 1;
      end
    end
    return n;
  endfunction

  function automatic logic [6:0] mpack(input mstate_t s);
    return {s.cnt[3:0], s.tick, s.tc, s.done};
  endfunction

  task automatic step();
    exp_t e;
    if (!rst_n) begin
      ma = mzero();
      mb = mzero();
    end else begin
      ma = mstep(ma, 4, 9);
      mb = mstep(mb, 1, 15);
    end
    q.push_back({mpack(ma), mpack(mb)});
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk_eq("a_state", 32'({a_count, a_tick, a_tc, a_done}), 32'(e.a));
    chk_eq("b_state", 32'({b_count, b_tick, b_tc, b_done}), 32'(e.b));
    if (a_tick) ticks_a++;
    if (a_tc)   tcs_a++;
    if (b_tc)   tcs_b++;
  endtask

  initial begin
    ma = mzero();
    mb = mzero();

    // reset state
    #1;
    chk_eq("rst_a", 32'({a_count, a_tick, a_tc, a_done}), 32'd0);
    chk_eq("rst_b", 32'({b_count, b_tick, b_tc, b_done}), 32'd0);
    repeat (2) step();

    // up, periodic from reset
    rst_n = 1'b1; enable = 1'b1; dir = 1'b0; oneshot = 1'b0;
    ticks_a = 0; tcs_a = 0;
    repeat (40) step();
    chk_eq("up_ticks", 32'(ticks_a), 32'd10);
    chk_eq("up_tc", 32'(tcs_a), 32'd1);
    chk_eq("up_wrap", 32'(a_count), 32'd0);

    // down, one-shot
    lv = 4'd3; load = 1'b1; step(); load = 1'b0;
    chk_eq("ld3", 32'(a_count), 32'd3);
    dir = 1'b1; oneshot = 1'b1; tcs_a = 0;
    repeat (16) step();
    chk_eq("os_cnt", 32'(a_count), 32'd0);
    chk_eq("os_done", 32'(a_done), 32'd1);
    chk_eq("os_tc", 32'(tcs_a), 32'd1);
    ticks_a = 0; tcs_a = 0;
    repeat (20) step();
    chk_eq("os_hold_ticks", 32'(ticks_a), 32'd5);
    chk_eq("os_hold_tc", 32'(tcs_a), 32'd0);
    chk_eq("os_hold_cnt", 32'(a_count), 32'd0);
    lv = 4'd5; load = 1'b1; step(); load = 1'b0;
    chk_eq("reld_cnt", 32'(a_count), 32'd5);
    chk_eq("reld_done", 32'(a_done), 32'd0);

    // clamp and priority
    dir = 1'b0; oneshot = 1'b0;
    lv = 4'd12; load = 1'b1; step(); load = 1'b0;
    chk_eq("clamp", 32'(a_count), 32'd9);
    repeat (3) step();
    load = 1'b1; step(); load = 1'b0;
    chk_eq("ld_vs_tick_cnt", 32'(a_count), 32'd9);
    chk_eq("ld_vs_tick_tc", 32'(a_tc), 32'd0);
    chk_eq("ld_vs_tick_tick", 32'(a_tick), 32'd0);
    lv = 4'd6; clear = 1'b1; load = 1'b1; step(); clear = 1'b0; load = 1'b0;
    chk_eq("clr_ld_cnt", 32'(a_count), 32'd0);
    chk_eq("clr_ld_done", 32'(a_done), 32'd0);

    // enable gating two cycles into a period
    repeat (2) step();
    enable = 1'b0; ticks_a = 0;
    repeat (10) step();
    chk_eq("gate_ticks", 32'(ticks_a), 32'd0);
    chk_eq("gate_cnt", 32'(a_count), 32'd0);
    enable = 1'b1;
    step();
    chk_eq("gate_resume1", 32'(a_tick), 32'd0);
    step();
    chk_eq("gate_resume2", 32'(a_tick), 32'd1);
    chk_eq("gate_resume_cnt", 32'(a_count), 32'd1);

    // asynchronous reset between edges
    clear = 1'b1; step(); clear = 1'b0;
    repeat (28) step();
    chk_eq("pre_rst_cnt", 32'(a_count), 32'd7);
    #3;
    rst_n = 1'b0;
    ma = mzero();
    mb = mzero();
    #1;
    chk_eq("async_rst_a", 32'({a_count, a_tick, a_tc, a_done}), 32'd0);
    chk_eq("async_rst_b", 32'({b_count, b_tick, b_tc, b_done}), 32'd0);
    step();
    rst_n = 1'b1; ticks_a = 0;
    repeat (3) step();
    chk_eq("post_rst_noticks", 32'(ticks_a), 32'd0);
    step();
    chk_eq("post_rst_tick", 32'(a_tick), 32'd1);
    chk_eq("post_rst_cnt", 32'(a_count), 32'd1);

    // PRESCALE=1 instance: wrap and direction flip
    clear = 1'b1; step(); clear = 1'b0;
    dir = 1'b0; oneshot = 1'b0; tcs_b = 0;
    repeat (15) step();
    chk_eq("b_top", 32'(b_count), 32'd15);
    step();
    chk_eq("b_wrap_cnt", 32'(b_count), 32'd0);
    chk_eq("b_wrap_tc", 32'(b_tc), 32'd1);
    chk_eq("b_tc_total", 32'(tcs_b), 32'd1);
    repeat (5) step();
    chk_eq("b_five", 32'(b_count), 32'd5);
    dir = 1'b1;
    step();
    chk_eq("b_flip", 32'(b_count), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
